// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Tag rd fields are stored zero-extended to this width; REG_ADDR_W must not exceed it.
  localparam int RD_MAX_W = 8;

  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                ld;
  } tag_t;

  function automatic int selW(input int fwdStages);
    return (fwdStages < 1) ? 1 : $clog2(fwdStages + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-stage operand/producer bus between the pipeline (master) and the hazard unit (slave).
interface fwd_hazard_unit_if import fwd_pkg::*; #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 16
) ();
  localparam int SEL_W = selW(FWD_STAGES);

  // ex_valid qualifies every ex_* field in the same cycle; there is no ready.
  // stall_ex is the back-pressure: while it is 1 the EX instruction is not
  // consumed and must be presented unchanged on the next cycle.
  logic                          ex_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src;
  logic [REG_ADDR_W-1:0]         ex_rd;
  logic                          ex_reg_write;
  logic                          ex_is_load;
  logic                          hold;
  logic                          flush;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall_ex;
  logic [CNT_W-1:0]              stall_cycles;

  modport master (
    output ex_valid, ex_src, ex_rd, ex_reg_write, ex_is_load, hold, flush,
    input  fwd_sel, stall_ex, stall_cycles
  );

  modport slave (
    input  ex_valid, ex_src, ex_rd, ex_reg_write, ex_is_load, hold, flush,
    output fwd_sel, stall_ex, stall_cycles
  );
endinterface

// File: rtl/fwd_src_match.sv
// Priority scan of the in-flight tags for one source operand: youngest live match wins.
module fwd_src_match import fwd_pkg::*; #(
  parameter int  FWD_STAGES = 2,
  parameter int  LOAD_LAT   = 1,
  localparam int SEL_W      = selW(FWD_STAGES)
) (
  input  logic                  exValid,
  input  tag_t [FWD_STAGES:1]   tags,
  input  logic [RD_MAX_W-1:0]   src,
  output logic [SEL_W-1:0]      sel,
  output logic                  loadHazard
);

  // Scan oldest to youngest so the last hit (lowest stage) overrides.
  always_comb begin
    sel        = SEL_W'(SEL_RF);
    loadHazard = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (exValid && (src != '0) && tags[k].valid && tags[k].wr &&
          (tags[k].rd == src)) begin
        sel        = SEL_W'(k);
        loadHazard = tags[k].ld && (k <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation from a private shift register of producer tags.
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_unit_if.slave  bus
);
  localparam int SEL_W = selW(FWD_STAGES);

  tag_t [FWD_STAGES:1]      tagQ;
  tag_t                     newTag;
  logic [NUM_SRC-1:0]       srcHazard;
  logic [NUM_SRC*SEL_W-1:0] selVec;
  logic                     stallEx;
  logic [CNT_W-1:0]         stallCnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    fwd_src_match #(
      .FWD_STAGES (FWD_STAGES),
      .LOAD_LAT   (LOAD_LAT)
    ) uMatch (
      .exValid    (bus.ex_valid),
      .tags       (tagQ),
      .src        (RD_MAX_W'(bus.ex_src[i*REG_ADDR_W +: REG_ADDR_W])),
      .sel        (selVec[i*SEL_W +: SEL_W]),
      .loadHazard (srcHazard[i])
    );
  end

  assign stallEx = bus.ex_valid && !bus.flush && (|srcHazard);

  always_comb begin
    newTag       = '0;
    newTag.valid = bus.ex_valid;
    newTag.rd    = RD_MAX_W'(bus.ex_rd);
    newTag.wr    = bus.ex_reg_write;
    newTag.ld    = bus.ex_is_load;
  end

  // A stall pushes a bubble into stage 1 while older producers keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagQ <= '0;
    end else if (bus.flush) begin
      tagQ <= '0;
    end else if (!bus.hold) begin
      tagQ[1] <= stallEx ? '0 : newTag;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        tagQ[k] <= tagQ[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallEx && !bus.hold && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign bus.fwd_sel      = selVec;
  assign bus.stall_ex     = stallEx;
  assign bus.stall_cycles = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus randomized traffic checked against a queue-based pipeline model.
module tb_fwd_hazard_unit;
  localparam int NS = 2;
  localparam int AW = 5;
  localparam int FS = 2;
  localparam int LL = 1;
  localparam int CW = 16;
  localparam int SW = $clog2(FS + 1);

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } prod_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  prod_t pipe[$];   // pipe[0] is the youngest producer (stage 1)
  int    m_cnt = 0;

  fwd_hazard_unit_if #(.NUM_SRC(NS), .REG_ADDR_W(AW), .FWD_STAGES(FS), .CNT_W(CW)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(NS), .REG_ADDR_W(AW), .FWD_STAGES(FS), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int src_of(int i);
    logic [NS*AW-1:0] v;
    v = bus.ex_src;
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic int model_sel(int src);
    if (!bus.ex_valid || src == 0) return 0;
    for (int k = 1; k <= FS; k++)
      if (pipe[k-1].valid && pipe[k-1].wr && pipe[k-1].rd == src) return k;
    return 0;
  endfunction

  function automatic bit model_stall();
    if (!bus.ex_valid || bus.flush) return 0;
    for (int i = 0; i < NS; i++) begin
      int k;
      k = model_sel(src_of(i));
      if (k != 0 && pipe[k-1].ld && k <= LL) return 1;
    end
    return 0;
  endfunction

  function automatic void model_clear();
    prod_t b;
    b = '{valid: 0, rd: 0, wr: 0, ld: 0};
    pipe.delete();
    for (int k = 0; k < FS; k++) pipe.push_back(b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      m_cnt = 0;
    end else begin
      bit    st;
      prod_t p;
      st = model_stall();
      if (st && !bus.hold && m_cnt < (2**CW - 1)) m_cnt++;
      if (bus.flush) model_clear();
      else if (!bus.hold) begin
        p = '{valid: 0, rd: 0, wr: 0, ld: 0};
        if (!st) p = '{valid: bus.ex_valid, rd: int'(bus.ex_rd), wr: bus.ex_reg_write, ld: bus.ex_is_load};
        pipe.push_front(p);
        void'(pipe.pop_back());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int s0, input int s1, input int rd, input bit wr, input bit ld);
    bus.ex_valid     = v;
    bus.ex_src       = {AW'(s1), AW'(s0)};
    bus.ex_rd        = AW'(rd);
    bus.ex_reg_write = wr;
    bus.ex_is_load   = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    drive(0, 0, 0, 0, 0, 0);
    bus.hold  = 0;
    bus.flush = 1;
    tick();
    bus.flush = 0;
  endtask

  function automatic logic [SW-1:0] sel_of(int i);
    logic [NS*SW-1:0] v;
    v = bus.fwd_sel;
    return v[i*SW +: SW];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 3, 4, 3, 1, 1);
    bus.hold = 0; bus.flush = 0;
    #1 rst_n = 0;
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(0)) begin miscompares++; $display("FAIL reset_sel0 got=%0d exp=0", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(0)) begin miscompares++; $display("FAIL reset_sel1 got=%0d exp=0", sel_of(1)); end
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", bus.stall_ex); end
    vectors++; if (bus.stall_cycles !== CW'(0)) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cycles); end
    #2 rst_n = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    clean();
    drive(1, 1, 2, 3, 1, 0);               // add r3
    tick();
    drive(1, 3, 4, 8, 1, 0);               // sub uses r3
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(1)) begin miscompares++; $display("FAIL b2b_sel0_stage1 got=%0d exp=1", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(0)) begin miscompares++; $display("FAIL b2b_sel1_rf got=%0d exp=0", sel_of(1)); end
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL b2b_stall got=%b exp=0", bus.stall_ex); end
    tick();
    drive(1, 3, 3, 9, 1, 0);               // third use of r3
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(2)) begin miscompares++; $display("FAIL b2b_sel0_stage2 got=%0d exp=2", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(2)) begin miscompares++; $display("FAIL b2b_sel1_stage2 got=%0d exp=2", sel_of(1)); end
    tick();
  endtask

  task automatic test_double_hit();
    clean();
    drive(1, 1, 1, 5, 1, 0); tick();
    drive(1, 2, 2, 5, 1, 0); tick();
    drive(1, 0, 5, 6, 1, 0);
    @(negedge clk);
    vectors++; if (sel_of(1) !== SW'(1)) begin miscompares++; $display("FAIL dbl_youngest got=%0d exp=1", sel_of(1)); end
    vectors++; if (sel_of(0) !== SW'(0)) begin miscompares++; $display("FAIL dbl_src0_r0 got=%0d exp=0", sel_of(0)); end
    clean();
    drive(1, 1, 1, 0, 1, 0); tick();
    drive(1, 2, 2, 0, 1, 1); tick();
    drive(1, 0, 0, 6, 1, 0);
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(0)) begin miscompares++; $display("FAIL dbl_rd0_sel0 got=%0d exp=0", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(0)) begin miscompares++; $display("FAIL dbl_rd0_sel1 got=%0d exp=0", sel_of(1)); end
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL dbl_rd0_stall got=%b exp=0", bus.stall_ex); end
    tick();
  endtask

  task automatic test_load_use();
    clean();
    drive(1, 1, 2, 7, 1, 1);               // lw r7
    tick();
    drive(1, 7, 0, 10, 1, 0);              // add uses r7
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b1) begin miscompares++; $display("FAIL lu_stall got=%b exp=1", bus.stall_ex); end
    vectors++; if (sel_of(0) !== SW'(1)) begin miscompares++; $display("FAIL lu_sel_during got=%0d exp=1", sel_of(0)); end
    vectors++; if (bus.stall_cycles !== CW'(0)) begin miscompares++; $display("FAIL lu_cnt_before got=%0d exp=0", bus.stall_cycles); end
    tick();
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL lu_stall_clear got=%b exp=0", bus.stall_ex); end
    vectors++; if (sel_of(0) !== SW'(2)) begin miscompares++; $display("FAIL lu_sel_after got=%0d exp=2", sel_of(0)); end
    vectors++; if (bus.stall_cycles !== CW'(1)) begin miscompares++; $display("FAIL lu_cnt_after got=%0d exp=1", bus.stall_cycles); end
    tick();
    drive(1, 10, 7, 11, 1, 0);             // add captured at stage 1, lw retired
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(1)) begin miscompares++; $display("FAIL lu_capture got=%0d exp=1", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(0)) begin miscompares++; $display("FAIL lu_retired got=%0d exp=0", sel_of(1)); end
    tick();
  endtask

  task automatic test_hold_stall();
    clean();
    drive(1, 1, 2, 7, 1, 1); tick();
    drive(1, 7, 0, 10, 1, 0);
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b1) begin miscompares++; $display("FAIL hs_stall got=%b exp=1", bus.stall_ex); end
    bus.hold = 1;
    for (int n = 0; n < 2; n++) begin
      tick();
      @(negedge clk);
      vectors++; if (bus.stall_ex !== 1'b1) begin miscompares++; $display("FAIL hs_held_stall got=%b exp=1", bus.stall_ex); end
      vectors++; if (sel_of(0) !== SW'(1)) begin miscompares++; $display("FAIL hs_frozen_sel got=%0d exp=1", sel_of(0)); end
      vectors++; if (bus.stall_cycles !== CW'(1)) begin miscompares++; $display("FAIL hs_cnt_frozen got=%0d exp=1", bus.stall_cycles); end
    end
    bus.hold = 0;
    tick();
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL hs_release got=%b exp=0", bus.stall_ex); end
    vectors++; if (sel_of(0) !== SW'(2)) begin miscompares++; $display("FAIL hs_fwd_resume got=%0d exp=2", sel_of(0)); end
    vectors++; if (bus.stall_cycles !== CW'(2)) begin miscompares++; $display("FAIL hs_cnt_inc got=%0d exp=2", bus.stall_cycles); end
    tick();
  endtask

  task automatic test_flush_hold();
    clean();
    drive(1, 1, 2, 7, 1, 1); tick();
    drive(1, 7, 7, 11, 1, 0);
    bus.flush = 1; bus.hold = 1;
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL fh_stall got=%b exp=0", bus.stall_ex); end
    vectors++; if (sel_of(0) !== SW'(1)) begin miscompares++; $display("FAIL fh_sel_comb got=%0d exp=1", sel_of(0)); end
    tick();
    bus.flush = 0; bus.hold = 0;
    @(negedge clk);
    vectors++; if (sel_of(0) !== SW'(0)) begin miscompares++; $display("FAIL fh_sel0 got=%0d exp=0", sel_of(0)); end
    vectors++; if (sel_of(1) !== SW'(0)) begin miscompares++; $display("FAIL fh_sel1 got=%0d exp=0", sel_of(1)); end
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL fh_stall_after got=%b exp=0", bus.stall_ex); end
    vectors++; if (bus.stall_cycles !== CW'(2)) begin miscompares++; $display("FAIL fh_cnt got=%0d exp=2", bus.stall_cycles); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    clean();
    drive(1, 1, 2, 7, 1, 1); tick();
    drive(1, 7, 7, 12, 1, 0);
    @(negedge clk);
    vectors++; if (bus.stall_ex !== 1'b1) begin miscompares++; $display("FAIL rms_pre_stall got=%b exp=1", bus.stall_ex); end
    #1 rst_n = 0;
    #1;
    vectors++; if (bus.stall_ex !== 1'b0) begin miscompares++; $display("FAIL rms_stall got=%b exp=0", bus.stall_ex); end
    vectors++; if (sel_of(0) !== SW'(0)) begin miscompares++; $display("FAIL rms_sel0 got=%0d exp=0", sel_of(0)); end
    vectors++; if (bus.stall_cycles !== CW'(0)) begin miscompares++; $display("FAIL rms_cnt got=%0d exp=0", bus.stall_cycles); end
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 6), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      bus.hold  = ($urandom_range(0, 9) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        int e;
        e = model_sel(src_of(i));
        vectors++;
        if (sel_of(i) !== SW'(e)) begin
          miscompares++; $display("FAIL rnd_sel%0d cycle=%0d got=%0d exp=%0d", i, n, sel_of(i), e);
        end
      end
      vectors++;
      if (bus.stall_ex !== model_stall()) begin
        miscompares++; $display("FAIL rnd_stall cycle=%0d got=%b exp=%b", n, bus.stall_ex, model_stall());
      end
      vectors++;
      if (bus.stall_cycles !== CW'(m_cnt)) begin
        miscompares++; $display("FAIL rnd_cnt cycle=%0d got=%0d exp=%0d", n, bus.stall_cycles, m_cnt);
      end
      tick();
    end
    bus.hold = 0; bus.flush = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.hold = 0; bus.flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_back_to_back();
    test_double_hit();
    test_load_use();
    test_hold_stall();
    test_flush_hold();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the integer pipeline.
- Keeps its own shift register of in-flight producer tags: destination register, write-enable and load flag for each stage after EX.
- For every source operand of the instruction currently in EX, it selects the youngest forwarding source, or the register file.
- Requests an EX stall and inserts a bubble when the matching producer is a load whose data is not yet available.

Parameters:
- NUM_SRC, 2: source operands per instruction.
- REG_ADDR_W, 5: register address width. Register 0 is hard-wired zero.
- FWD_STAGES, 2: number of post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, ...). Must be >= 1.
- LOAD_LAT, 1: stages after EX in which load data is not yet available. Must be < FWD_STAGES.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_src  in  NUM_SRC*REG_ADDR_W  source register addresses of the EX instruction; src i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_reg_write  in  1  EX instruction writes ex_rd.
- ex_is_load  in  1  EX instruction is a load.
- hold  in  1  global freeze (memory wait). No tag movement.
- flush  in  1  kill all in-flight tags (branch/exception).
- fwd_sel  out  NUM_SRC*SEL_W  per-source select; SEL_W = clog2(FWD_STAGES+1). 0 = register file, k = stage k.
- stall_ex  out  1  hold IF/ID/EX this cycle; bubble enters stage 1.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_ex = 1.

Behaviour:
- Tag entry k (1..FWD_STAGES) holds {valid, rd, wr, ld}.
- A producer is live at stage k when valid && wr && rd != 0.
- Reset (async, rst_n = 0): all entries invalid, stall_cycles = 0. Outputs therefore reset to fwd_sel = 0 and stall_ex = 0.
- Match for source i at stage k: ex_valid, producer live at stage k, rd == src_i, src_i != 0.
- Forwarding priority: lowest k (youngest) wins.
  - Chosen k gives fwd_sel_i = k. No match gives 0.
  - Matches at older stages are ignored.
- Load-use check: if the winning match for any source has ld = 1 and k <= LOAD_LAT, then stall_ex = 1.
- stall_ex is forced to 0 when flush = 1 or ex_valid = 0.
- fwd_sel and stall_ex are combinational from the registers and current inputs. Latency is 0 (same cycle).
- Sequencing on each rising edge, in priority order:
  - flush: all entries invalid. Overrides hold.
  - else hold: all entries keep their value. stall_cycles unchanged.
  - else stall_ex: entries k >= 2 shift from k-1; entry 1 becomes invalid (bubble). The EX instruction is not captured.
  - else normal shift: entry 1 takes {ex_valid, ex_rd, ex_reg_write, ex_is_load}; entries k >= 2 shift from k-1.
- Entry FWD_STAGES is discarded on a shift (writeback complete).
- Stall duration: consecutive stall cycles equal LOAD_LAT - k + 1 for a load first seen at stage k. Afterwards the load sits at stage LOAD_LAT + 1 and forwards from there.
- stall_cycles increments by 1 on each edge where stall_ex = 1 and hold = 0. It saturates at all-ones.
- Both sources matching the same or different stages are resolved independently. A stall from either source stalls the whole EX stage.
- fwd_sel stays valid while stalled; the consumer ignores it until the stall clears.

Decomposition:
- Shared package fwd_pkg holds:
  - tag_t struct {valid, rd, wr, ld};
  - the SEL_W function (clog2);
  - the constant SEL_RF = 0.
- One sub-module, fwd_src_match, is instantiated NUM_SRC times. Input: the tag array and one source address. Outputs: sel and load_hazard, via a priority scan.
- The top level holds the tag shift register, stall OR-reduce and counter.

Test Plan:
- Back-to-back ALU: add r3 (cycle 0), then sub using r3 as src0 (cycle 1). Required: fwd_sel0 = 1, stall_ex = 0. One cycle later a third use of r3 gives fwd_sel = 2.
- Double hit: r5 written at stage 1 and stage 2, consumer src1 = r5. Required: fwd_sel1 = 1 (youngest wins). With rd = 0 at both stages: fwd_sel = 0.
- Load-use (LOAD_LAT = 1): lw r7, then add with src0 = r7. Required: exactly 1 cycle of stall_ex = 1, stage 1 becomes a bubble, then fwd_sel0 = 2, and stall_cycles goes 0 -> 1.
- Hold during stall: assert hold in the stall cycle. Required: tags frozen, stall_ex stays 1, stall_cycles unchanged. Release hold: 1 more stall edge, then forwarding resumes.
- Flush with hold: assert flush and hold together while a load is at stage 1. Required: stall_ex = 0 that cycle, all entries invalid next cycle, fwd_sel = 0 for any source.
- Reset mid-stall: drop rst_n while stall_ex = 1. Required: stall_ex = 0, fwd_sel = 0 and stall_cycles = 0 immediately, without waiting for a clock edge.
